// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings for the snake engine: directions, FSM states, death causes.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_WALL = 2'd1;
  localparam logic [1:0] CAUSE_SELF = 2'd2;

  // Opposite pairs differ only in bit 0 (UP/DOWN, RIGHT/LEFT).
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - step prescaler; tick marks the terminal count of TICK_CYCLES << speed_sel.
module snake_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] speed_sel,
  output logic       tick
);

  localparam int CW = $clog2(TICK_CYCLES) + 4;

  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  assign limit = (CW'(TICK_CYCLES) << speed_sel) - CW'(1);
  assign tick  = enable && (cnt == limit);

  // A counter left above a freshly lowered limit clears instead of firing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt >= limit) cnt <= '0;
      else              cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - parametrised snake body, timer, direction arbitration, growth and death.
// Optional SNAKE_WRAP_EN: head wraps at the playfield edges instead of dying on the wall.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int MAX_LEN     = 64,
  parameter int INIT_LEN    = 3,
  parameter int TICK_CYCLES = 50_000_000,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic [1:0]            speed_sel,
  input  logic [1:0]            dir_req,
  input  logic                  dir_valid,
  input  logic [XW-1:0]         food_x,
  input  logic [YW-1:0]         food_y,
  input  logic                  food_valid,
  output logic [1:0]            cur_dir,
  output logic [MAX_LEN*XW-1:0] body_x,
  output logic [MAX_LEN*YW-1:0] body_y,
  output logic [LW-1:0]         length,
  output logic [1:0]            state,
  output logic                  step_pulse,
  output logic                  ate_pulse,
  output logic [1:0]            death_cause
);

  localparam logic [XW:0]   X_LIM    = (XW+1)'(GRID_W);
  localparam logic [YW:0]   Y_LIM    = (YW+1)'(GRID_H);
  localparam logic [XW:0]   X_ONE    = (XW+1)'(1);
  localparam logic [YW:0]   Y_ONE    = (YW+1)'(1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);

  logic [XW-1:0] bx     [MAX_LEN];
  logic [YW-1:0] by     [MAX_LEN];
  logic [XW-1:0] init_x [MAX_LEN];
  logic [YW-1:0] init_y [MAX_LEN];
  logic [1:0]    pend_dir;
  state_t        st, st_nx;
  logic          tick, wall, eat, grow, self_hit;
  logic [XW:0]   nx;
  logic [YW:0]   ny;

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    if (i < INIT_LEN) begin : g_live
      assign init_x[i] = XW'(GRID_W / 2);
      assign init_y[i] = YW'(GRID_H / 2 + i);
    end else begin : g_empty
      assign init_x[i] = '0;
      assign init_y[i] = '0;
    end
    assign body_x[i*XW +: XW] = bx[i];
    assign body_y[i*YW +: YW] = by[i];
  end

  snake_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .enable    ((st == ST_RUN) && !pause),
    .clear     (start),
    .speed_sel (speed_sel),
    .tick      (tick)
  );

  // Head math is one bit wider so a step below zero lands far above the limit.
  always_comb begin
    nx = {1'b0, bx[0]};
    ny = {1'b0, by[0]};
    case (pend_dir)
      DIR_UP:    ny = ny - Y_ONE;
      DIR_DOWN:  ny = ny + Y_ONE;
      DIR_RIGHT: nx = nx + X_ONE;
      default:   nx = nx - X_ONE;
    endcase
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
    if (nx == X_LIM)     nx = '0;
    else if (nx > X_LIM) nx = X_LIM - X_ONE;
    if (ny == Y_LIM)     ny = '0;
    else if (ny > Y_LIM) ny = Y_LIM - Y_ONE;
`else
    wall = (nx >= X_LIM) || (ny >= Y_LIM);
`endif
    eat  = food_valid && (nx == {1'b0, food_x}) && (ny == {1'b0, food_y});
    grow = eat && (length < LEN_MAX);
    // The tail only counts as an obstacle when it stays put because we grow.
    self_hit = 1'b0;
    for (int j = 1; j < MAX_LEN; j++) begin
      if ((LW'(j + 1) < length) || (grow && (LW'(j + 1) == length))) begin
        if (({1'b0, bx[j]} == nx) && ({1'b0, by[j]} == ny)) self_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (start)                                     st_nx = ST_RUN;
    else if (st == ST_RUN && tick && (wall || self_hit)) st_nx = ST_DEAD;
  end

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bx          <= init_x;
      by          <= init_y;
      length      <= LEN_INIT;
      cur_dir     <= DIR_UP;
      pend_dir    <= DIR_UP;
      death_cause <= CAUSE_NONE;
      step_pulse  <= 1'b0;
      ate_pulse   <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      ate_pulse  <= 1'b0;
      if (start) begin
        bx          <= init_x;
        by          <= init_y;
        length      <= LEN_INIT;
        cur_dir     <= DIR_UP;
        pend_dir    <= DIR_UP;
        death_cause <= CAUSE_NONE;
      end else begin
        if (st == ST_RUN && dir_valid && dir_req != opposite(cur_dir)) pend_dir <= dir_req;
        if (tick) begin
          cur_dir <= pend_dir;
          if (wall) begin
            death_cause <= CAUSE_WALL;
          end else if (self_hit) begin
            death_cause <= CAUSE_SELF;
          end else begin
            bx[0] <= nx[XW-1:0];
            by[0] <= ny[YW-1:0];
            for (int j = 1; j < MAX_LEN; j++) begin
              if ((LW'(j) < length) || (grow && (LW'(j) == length))) begin
                bx[j] <= bx[j-1];
                by[j] <= by[j-1];
              end
            end
            if (grow) length <= length + LW'(1);
            step_pulse <= 1'b1;
            ate_pulse  <= eat;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - directed self-checking bench for snake_engine (32x24, MAX_LEN=5, TICK_CYCLES=4).
module tb_snake_engine;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int ML = 5;
  localparam int IL = 3;
  localparam int TC = 4;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int LW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            pause;
  logic [1:0]      speed_sel;
  logic [1:0]      dir_req;
  logic            dir_valid;
  logic [XW-1:0]   food_x;
  logic [YW-1:0]   food_y;
  logic            food_valid;
  logic [1:0]      cur_dir;
  logic [ML*XW-1:0] body_x;
  logic [ML*YW-1:0] body_y;
  logic [LW-1:0]   length;
  logic [1:0]      state;
  logic            step_pulse;
  logic            ate_pulse;
  logic [1:0]      death_cause;

  int passed = 0;
  int total  = 0;
  int n;
  int pulses;

  snake_engine #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .TICK_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .speed_sel(speed_sel),
    .dir_req(dir_req), .dir_valid(dir_valid), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .cur_dir(cur_dir), .body_x(body_x), .body_y(body_y),
    .length(length), .state(state), .step_pulse(step_pulse), .ate_pulse(ate_pulse),
    .death_cause(death_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int seg_x(input int i);
    return int'(body_x[i*XW +: XW]);
  endfunction

  function automatic int seg_y(input int i);
    return int'(body_y[i*YW +: YW]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_seg(input string tag, input int i, input int x, input int y);
    chk({tag, ".x"}, seg_x(i), x);
    chk({tag, ".y"}, seg_y(i), y);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic req(input logic [1:0] d);
    dir_req   = d;
    dir_valid = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  // Returns after the cycle showing step_pulse or after leaving RUN, bounded.
  task automatic wait_step(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!step_pulse && state == 2'd1 && cnt < 100);
    if (cnt >= 100) chk("wait_step timeout", cnt, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; speed_sel = 2'd0;
    dir_req = 2'd0; dir_valid = 1'b0; food_x = '0; food_y = '0; food_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst state", state, 0);
    chk("rst length", length, 3);
    chk("rst cur_dir", cur_dir, 0);
    chk("rst cause", death_cause, 0);
    chk("rst step_pulse", step_pulse, 0);
    chk("rst ate_pulse", ate_pulse, 0);
    chk_seg("rst seg0", 0, 16, 12);
    chk_seg("rst seg1", 1, 16, 13);
    chk_seg("rst seg2", 2, 16, 14);
    chk_seg("rst seg3", 3, 0, 0);
    rst = 1'b0;

    // IDLE holds still
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    chk("idle pulses", pulses, 0);
    chk("idle state", state, 0);

    // Start and three steps UP
    pulse_start();
    chk("start state", state, 1);
    wait_step(n);
    chk("step1 latency", n, 4);
    chk_seg("step1 head", 0, 16, 11);
    wait_step(n);
    chk("step2 period", n, 4);
    chk_seg("step2 head", 0, 16, 10);
    wait_step(n);
    chk("step3 period", n, 4);
    chk_seg("step3 head", 0, 16, 9);
    chk("step3 length", length, 3);

    // Reversal rejected, later legal request wins
    req(2'd1);
    req(2'd2);
    wait_step(n);
    chk_seg("rev head", 0, 17, 9);
    chk("rev cur_dir", cur_dir, 2);
    chk_seg("rev seg2", 2, 16, 10);

    // Growth 3 -> 4 -> 5, then saturation at MAX_LEN
    food_x = 5'd18; food_y = 5'd9; food_valid = 1'b1;
    wait_step(n);
    chk("grow1 ate", ate_pulse, 1);
    chk("grow1 length", length, 4);
    chk_seg("grow1 head", 0, 18, 9);
    chk_seg("grow1 new tail", 3, 16, 10);
    food_x = 5'd19;
    @(negedge clk);
    chk("ate one cycle", ate_pulse, 0);
    wait_step(n);
    chk("grow2 length", length, 5);
    chk_seg("grow2 tail", 4, 16, 10);
    food_x = 5'd20;
    wait_step(n);
    chk("sat ate", ate_pulse, 1);
    chk("sat length", length, 5);
    chk_seg("sat head", 0, 20, 9);
    chk_seg("sat tail", 4, 16, 9);
    food_valid = 1'b0;

    // Self collision: UP, RIGHT, DOWN, LEFT at length 5
    req(2'd0); wait_step(n);
    chk_seg("self up", 0, 20, 8);
    req(2'd2); wait_step(n);
    chk_seg("self right", 0, 21, 8);
    req(2'd1); wait_step(n);
    chk_seg("self down", 0, 21, 9);
    req(2'd3); wait_step(n);
    chk("self state", state, 2);
    chk("self cause", death_cause, 2);
    chk("self no step", step_pulse, 0);
    chk_seg("self frozen head", 0, 21, 9);
    chk_seg("self frozen seg3", 3, 20, 9);
    chk("self length", length, 5);

    // Restart from DEAD
    pulse_start();
    chk("restart state", state, 1);
    chk("restart cause", death_cause, 0);
    chk("restart length", length, 3);
    chk("restart cur_dir", cur_dir, 0);
    chk_seg("restart head", 0, 16, 12);
    chk_seg("restart seg3", 3, 0, 0);
    chk_seg("restart seg4", 4, 0, 0);

    // Tail chase at length 4 survives
    food_x = 5'd16; food_y = 5'd11; food_valid = 1'b1;
    wait_step(n);
    chk("chase grow length", length, 4);
    food_valid = 1'b0;
    req(2'd2); wait_step(n);
    req(2'd1); wait_step(n);
    chk_seg("chase pre head", 0, 17, 12);
    req(2'd3); wait_step(n);
    chk("chase state", state, 1);
    chk("chase step", step_pulse, 1);
    chk_seg("chase head", 0, 16, 12);
    chk_seg("chase tail", 3, 16, 11);

    // Pause across the terminal count
    repeat (3) @(negedge clk);
    pause = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    chk("pause pulses", pulses, 0);
    chk_seg("pause head", 0, 16, 12);
    pause = 1'b0;
    wait_step(n);
    chk("pause resume latency", n, 1);
    chk_seg("pause resume head", 0, 15, 12);

    // Slower speed doubles the period
    speed_sel = 2'd1;
    wait_step(n);
    chk("speed1 period", n, 8);
    chk_seg("speed1 head", 0, 14, 12);
    speed_sel = 2'd0;

    // Wall death after 13 steps UP from (16,12)
    pulse_start();
    pulses = 0;
    for (int k = 0; k < 13; k++) begin
      wait_step(n);
      if (step_pulse) pulses++;
    end
    chk("wall steps", pulses, 12);
    chk("wall state", state, 2);
    chk("wall cause", death_cause, 1);
    chk_seg("wall head", 0, 16, 0);
    chk_seg("wall seg1", 1, 16, 1);
    chk("wall length", length, 3);

    // Asynchronous reset on a terminal-count cycle
    pulse_start();
    wait_step(n);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst state", state, 0);
    chk_seg("midrst head", 0, 16, 12);
    @(negedge clk);
    chk("midrst step", step_pulse, 0);
    chk("midrst ate", ate_pulse, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
